// File: rtl/core_pkg.sv
// Shared types and constants for the register-file scoreboard and its
// write-port arbiter.
package core_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [NUM_REGS-1:0]   reg_vec_t;
  typedef logic [DATA_W-1:0]     reg_data_t;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_BUBBLE = 1'b1
  } arb_state_t;

  // One register-file write request from either writeback source.
  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;

  function automatic reg_vec_t reg_onehot(input reg_addr_t addr);
    reg_vec_t v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue, writeback and register-file write-port signals of the scoreboard.
interface reg_scoreboard_if;
  import core_pkg::*;

  logic      id_valid;
  reg_addr_t id_rs1_addr;
  reg_addr_t id_rs2_addr;
  logic      id_rs1_used;
  logic      id_rs2_used;
  reg_addr_t id_rd_addr;
  logic      id_rd_we;
  logic      id_long;
  logic      ex_ready;
  logic      id_stall;
  logic      id_fire;

  logic      a_valid;
  reg_addr_t a_addr;
  reg_data_t a_data;
  logic      b_valid;
  reg_addr_t b_addr;
  reg_data_t b_data;
  logic      b_ready;

  logic      rf_w_enabled;
  reg_addr_t rf_rd_addr;
  reg_data_t rf_rd_data;
  reg_vec_t  busy_out;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rd_addr, id_rd_we, id_long, ex_ready,
           a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  id_stall, id_fire, b_ready,
           rf_w_enabled, rf_rd_addr, rf_rd_data, busy_out
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rd_addr, id_rd_we, id_long, ex_ready,
           a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output id_stall, id_fire, b_ready,
           rf_w_enabled, rf_rd_addr, rf_rd_data, busy_out
  );

endinterface

// File: rtl/wb_port_arbiter.sv
// Combinational owner select for the single register-file write port:
// pipeline writeback (A) always wins, long-latency results (B) take what is left.
module wb_port_arbiter
  import core_pkg::*;
(
  input  logic      rstn,
  input  logic      in_bubble,
  input  wb_req_t   a,
  input  wb_req_t   b,
  output logic      b_ready,
  output logic      rf_we,
  output reg_addr_t rf_addr,
  output reg_data_t rf_data
);

  wb_req_t owner;
  logic    owner_live;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    owner = '0;
    if (a.valid) begin
      owner = a;
    end else if (in_bubble || b.valid) begin
      owner = b;
    end
  end

  assign owner_live = rstn && owner.valid;

  // A has no backpressure, so B is only ever accepted on cycles A is silent.
  assign b_ready = rstn && !a.valid;

  // x0 is architecturally zero: the write is dropped, not redirected.
  assign rf_we   = owner_live && (owner.addr != '0);
  assign rf_addr = owner_live ? owner.addr : '0;
  assign rf_data = owner_live ? owner.data : '0;

endmodule

// File: rtl/reg_scoreboard.sv
// Register hazard scoreboard for long-latency ops plus write-port arbitration
// with a starvation guard that forces an issue bubble so B can drain.
module reg_scoreboard
  import core_pkg::*;
#(
  parameter int MAX_LONG     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic             clk,
  input logic             rstn,
  reg_scoreboard_if.slave bus
);

  localparam int CNT_W = 4;
  localparam int STV_W = 8;
  localparam logic [CNT_W-1:0] LONG_MAX    = CNT_W'(MAX_LONG);
  localparam logic [STV_W-1:0] STARVE_MAX  = STV_W'(STARVE_LIMIT);
  localparam logic [STV_W-1:0] STARVE_LAST = STV_W'(STARVE_LIMIT - 1);

  reg_vec_t         busy;
  logic [CNT_W-1:0] long_cnt;
  logic [STV_W-1:0] starve_cnt;
  arb_state_t       arb_state;

  wb_req_t   a_req;
  wb_req_t   b_req;
  logic      b_ready;
  logic      b_acc;
  reg_vec_t  clr_vec;
  reg_vec_t  set_vec;
  reg_vec_t  eff_busy;
  logic      id_stall;
  logic      id_fire;
  logic      long_fire;

  assign a_req = '{valid: bus.a_valid, addr: bus.a_addr, data: bus.a_data};
  assign b_req = '{valid: bus.b_valid, addr: bus.b_addr, data: bus.b_data};

  wb_port_arbiter u_arb (
    .rstn      (rstn),
    .in_bubble (arb_state == ARB_BUBBLE),
    .a         (a_req),
    .b         (b_req),
    .b_ready   (b_ready),
    .rf_we     (bus.rf_w_enabled),
    .rf_addr   (bus.rf_rd_addr),
    .rf_data   (bus.rf_rd_data)
  );

  assign b_acc   = bus.b_valid && b_ready;
  assign clr_vec = b_acc ? reg_onehot(bus.b_addr) : '0;

  // The register file bypasses a same-cycle write to its read ports, so a
  // completing result can release its consumer in the very same cycle.
  assign eff_busy = busy & ~clr_vec;

  always_comb begin
    id_stall = !rstn || (arb_state == ARB_BUBBLE);
    if (bus.id_valid) begin
      if (bus.id_rs1_used && eff_busy[bus.id_rs1_addr]) id_stall = 1'b1;
      if (bus.id_rs2_used && eff_busy[bus.id_rs2_addr]) id_stall = 1'b1;
      if (bus.id_rd_we    && eff_busy[bus.id_rd_addr])  id_stall = 1'b1;
      if (bus.id_long && (long_cnt == LONG_MAX) && !b_acc) id_stall = 1'b1;
    end
  end

  assign id_fire   = bus.id_valid && !id_stall && bus.ex_ready;
  assign long_fire = id_fire && bus.id_long;
  assign set_vec   = (long_fire && bus.id_rd_we && (bus.id_rd_addr != '0))
                     ? reg_onehot(bus.id_rd_addr) : '0;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy <= '0;
    end else begin
      busy <= ((busy & ~clr_vec) | set_vec) & ~reg_vec_t'(1);
    end
  end

  // Long ops to x0 or without rd_we still occupy a slot until B returns them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      long_cnt <= '0;
    end else begin
      case ({long_fire, b_acc})
        2'b10:   long_cnt <= long_cnt + 4'd1;
        2'b01:   if (long_cnt != '0) long_cnt <= long_cnt - 4'd1;
        default: long_cnt <= long_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      arb_state  <= ARB_NORMAL;
      starve_cnt <= '0;
    end else begin
      case (arb_state)
        ARB_NORMAL: begin
          if (bus.b_valid && bus.a_valid) begin
            if (starve_cnt == STARVE_LAST) begin
              arb_state  <= ARB_BUBBLE;
              starve_cnt <= STARVE_MAX;
            end else begin
              starve_cnt <= starve_cnt + 8'd1;
            end
          end else begin
            starve_cnt <= '0;
          end
        end
        ARB_BUBBLE: begin
          // Issue is held, so A drains within the pipeline depth and B gets in.
          if (b_acc) begin
            arb_state  <= ARB_NORMAL;
            starve_cnt <= '0;
          end
        end
        default: begin
          arb_state  <= ARB_NORMAL;
          starve_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.id_stall = id_stall;
  assign bus.id_fire  = id_fire;
  assign bus.b_ready  = b_ready;
  assign bus.busy_out = busy;

  a_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
    b_acc |-> (long_cnt != '0))
    else $error("reg_scoreboard: B accepted with no long op outstanding");

  a_clear_owned: assert property (@(posedge clk) disable iff (!rstn)
    (b_acc && (bus.b_addr != '0)) |-> busy[bus.b_addr])
    else $error("reg_scoreboard: B completion to a register not marked busy");

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-file hazard scoreboard and write-port arbiter for the in-order RISC-V core. It sits between decode/issue and the single-write-port `register` file. It tracks destination registers owned by outstanding long-latency operations (loads, mul/div) and stalls issue on RAW/WAW hazards against them. It also arbitrates the one register-file write port between the in-order pipeline writeback and the long-latency completion path, with a starvation guard.

## Interface
- `MAX_LONG`, default 4: maximum outstanding long-latency ops (1..15).
- `STARVE_LIMIT`, default 8: consecutive cycles source B may be denied before a bubble is forced (2..255).
- `clk` in 1: core clock.
- `rstn` in 1: reset. Asynchronous, active-low.
- `id_valid` in 1: an instruction is presented at issue.
- `id_rs1_addr` / `id_rs2_addr` in 5 each: source register addresses.
- `id_rs1_used` / `id_rs2_used` in 1 each: the corresponding source is read.
- `id_rd_addr` in 5: destination register.
- `id_rd_we` in 1: the instruction writes `rd`.
- `id_long` in 1: the instruction is long-latency; its result returns on source B.
- `ex_ready` in 1: the downstream stage accepts the instruction.
- `id_stall` out 1: issue must hold.
- `id_fire` out 1: the instruction issues this cycle.
- `a_valid` in 1: pipeline writeback valid. This source has no backpressure.
- `a_addr` in 5, `a_data` in 32: pipeline writeback address and data.
- `b_valid` in 1: long-latency result valid.
- `b_addr` in 5, `b_data` in 32: long-latency result address and data.
- `b_ready` out 1: the long-latency result is accepted this cycle.
- `rf_w_enabled` out 1, `rf_rd_addr` out 5, `rf_rd_data` out 32: drive the register file's write port.
- `busy_out` out 32: scoreboard vector, for debug.

## Operation
- State:
  - `busy[31:0]`
  - `long_cnt` (0..MAX_LONG)
  - `starve_cnt` (0..STARVE_LIMIT)
  - arbiter FSM `{ARB_NORMAL, ARB_BUBBLE}`
- `busy[0]` is hardwired to 0.
- Write arbitration (combinational):
  - If `a_valid`, A owns the port.
  - Else, in ARB_BUBBLE or with `b_valid`, B owns the port.
  - `b_ready = rstn && !a_valid`.
  - `b_acc = b_valid && b_ready`.
- Write-port rules:
  - `rf_w_enabled` = the owner is valid and its address is nonzero. A write to x0 never reaches the register file.
  - `rf_rd_addr` and `rf_rd_data` are muxed from the owner.
  - When no source is active they are 0.
- Clear condition: `clr_vec` is the one-hot of `b_addr` when `b_acc`, else 0.
- Hazard check uses `eff_busy = busy & ~clr_vec`. This is safe because the register file bypasses the same-cycle write to its read ports.
- `id_stall` is 1 if any of the following holds:
  - `!rstn`
  - `id_valid` and `id_rs1_used` and `eff_busy[rs1]`
  - `id_valid` and `id_rs2_used` and `eff_busy[rs2]`
  - `id_valid` and `id_rd_we` and `eff_busy[rd]` (WAW)
  - `id_valid` and `id_long` and `long_cnt == MAX_LONG` and not `b_acc`
  - the FSM is in ARB_BUBBLE
- `id_fire = id_valid && !id_stall && ex_ready`.
- Next-state update:
  - `busy <= (busy & ~clr_vec) | set_vec`, where `set_vec` is the one-hot of `id_rd_addr` when `id_fire && id_long && id_rd_we && rd != 0`.
  - `long_cnt` increments on a long fire and decrements on `b_acc`. Both in the same cycle leave it unchanged.
  - A long op with `rd == x0` or `!id_rd_we` still counts in `long_cnt`. Its B completion clears nothing.
- Starvation FSM:
  - ARB_NORMAL: `starve_cnt` increments while `b_valid && a_valid`, and resets to 0 otherwise. On reaching `STARVE_LIMIT`, go to ARB_BUBBLE.
  - ARB_BUBBLE: issue is stalled, so A drains within pipeline depth. On `b_acc`, return to ARB_NORMAL with `starve_cnt = 0`.
- Errors:
  - `b_acc` while `long_cnt == 0` is a protocol error. Simulation assertion only; the counter saturates at 0.
  - `b_acc` to an address whose busy bit is clear: simulation assertion only.

## Timing
- Reset values: `busy = 0`, `long_cnt = 0`, `starve_cnt = 0`, FSM = ARB_NORMAL.
- Output values during reset: `id_stall = 1`, `id_fire = 0`, `b_ready = 0`, `rf_w_enabled = 0`, `busy_out = 0`.
- `id_stall`, `id_fire`, `b_ready` and the `rf_*` outputs are combinational from the inputs and registered state, with zero latency.
- Busy bits set at the posedge after fire. The next cycle's issue sees them.
- A B completion unblocks a stalled consumer in the same cycle.
- Reset mid-operation discards all tracking. Upstream units are reset together.

## Structure
- Shared package `core_pkg`:
  - `arb_state_t` enum
  - `REG_ADDR_W = 5`
  - `NUM_REGS = 32`
- One sub-module, `wb_port_arbiter`: the combinational owner mux, `b_ready` and the x0 suppression.
- The scoreboard, counters and FSM stay in the top module.

## Test plan
- Issue long load to x5. Next cycle, issue `add x6, x5, x1` → stall until B returns x5. On the B-accept cycle `id_stall = 0` and `busy[5]` drops.
- Long op to x7 outstanding; issue ALU op writing x7 → WAW stall; released on the B completion of x7.
- `MAX_LONG = 4` long ops outstanding; fifth long issue → stall. B completes one in the same cycle → the fifth issues and `long_cnt` stays 4.
- `a_valid` and `b_valid` held high for 8 cycles → FSM enters ARB_BUBBLE and `id_stall = 1`. The A writes drain, B is accepted, and the FSM returns to ARB_NORMAL.
- A write to x0 with `a_data = 0xDEADBEEF` → `rf_w_enabled = 0`. A long op to x0 → `busy` unchanged and `long_cnt` increments.
- Assert `rstn` low with 3 long ops outstanding → all outputs take their reset values immediately. After release, `busy = 0`.
